tomasulo_cdb_arbiter: RTL
=========================

# tomasulo_cdb_arbiter

Common Data Bus arbiter downstream of the Tomasulo functional units. Each unit pushes a completed result (producer tag + value) into a small per-unit FIFO; the arbiter grants one FIFO per cycle round-robin and broadcasts the winner on a registered CDB. Reservation stations and the register bank consume the CDB to clear tags and capture values.

## Interface
Parameters:
- NUM_FU, 3, number of functional-unit result ports
- DATA_W, 16, result value width
- TAG_W, 4, producer tag width; tag 0 means "no producer"
- FIFO_DEPTH, 2, entries per unit FIFO (power of two, ≥2)

Ports:
- clk1  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous discard of all buffered results
- fu_valid  in  NUM_FU  unit i presents a result
- fu_ready  out  NUM_FU  FIFO i can accept
- fu_tag  in  NUM_FU*TAG_W  tag of unit i at bits [i*TAG_W +: TAG_W]
- fu_data  in  NUM_FU*DATA_W  value of unit i, same packing
- cdb_valid  out  1  broadcast valid this cycle
- cdb_tag  out  TAG_W  broadcast producer tag
- cdb_data  out  DATA_W  broadcast value
- drop_cnt  out  8  count of results discarded because tag was 0, saturating

## Operation
- Push: FIFO i pushes when fu_valid[i] && fu_ready[i]. fu_ready[i] = (count_i < FIFO_DEPTH); no same-cycle pop/push bypass when full.
- Results with tag 0 are accepted (handshake completes) but not stored; drop_cnt increments, saturating at 255.
- Arbitration: among non-empty FIFOs, grant the first index at or after rr_ptr (wrapping modulo NUM_FU). Granted FIFO pops its head that cycle; rr_ptr <= grant+1 (mod NUM_FU). No request: rr_ptr holds.
- CDB register: cdb_valid <= granted; cdb_tag/cdb_data <= popped head. No grant: cdb_valid <= 0, tag/data hold last value.
- A FIFO may push and pop in the same cycle when not full; count unchanged, ordering preserved.
- flush: all FIFO counts and pointers cleared, cdb_valid <= 0, no push accepted that cycle, no pop, rr_ptr and drop_cnt unchanged. flush has priority over everything except rst.
- Per-unit order is FIFO; cross-unit order is arbitration order only.

## Timing
- Reset (async assert): cdb_valid=0, cdb_tag=0, cdb_data=0, drop_cnt=0, rr_ptr=0, all FIFOs empty, fu_ready all 1 immediately after reset value settles.
- Latency: result pushed at edge N into an empty FIFO is eligible at edge N+1 and appears on CDB after edge N+1 at earliest (one cycle visible).
- Throughput: one CDB broadcast per cycle; with k non-empty FIFOs each is served within k cycles.
- fu_ready is a function of registered count only (no combinational path from cdb or fu_valid).
- Reset mid-operation: buffered results lost; outputs return to reset values without waiting for a clock.
- Counter wrap: FIFO read/write pointers wrap modulo FIFO_DEPTH; rr_ptr wraps NUM_FU-1 → 0.

## Structure
- tomasulo_pkg: TAG_W, DATA_W, NULL_TAG = 0, shared with reservation stations and register bank.
- Sub-module cdb_fifo (parameters DATA_W+TAG_W, FIFO_DEPTH; ports push, pop, clr, din, dout, count), instantiated NUM_FU times via generate.
- Arbiter and CDB register in the top module.

## Test plan
- Reset: assert rst with garbage inputs → cdb_valid=0, cdb_tag=0, drop_cnt=0, fu_ready=3'b111.
- Single result: fu_valid[1]=1, tag=5, data=16'h00AB for one cycle → next cycle cdb_valid=1, cdb_tag=5, cdb_data=16'h00AB, then cdb_valid=0.
- Contention: all three units push tags 1,2,3 same cycle with rr_ptr=0 → CDB shows 1,2,3 on three consecutive cycles; second burst tags 4,5,6 → 4,5,6 (rr_ptr back at 0).
- Full/backpressure: unit 0 pushes tags 7,8,9 back-to-back while unit 2 holds priority → fu_ready[0]=0 after two stored entries, third held; all three eventually broadcast in order 7,8,9.
- Null tag: push tag 0 on unit 2 → fu_ready stays 1, no CDB broadcast, drop_cnt=1; 300 such pushes → drop_cnt=255.
- Flush: fill unit 0 and unit 1 FIFOs, assert flush one cycle → cdb_valid=0 next cycle and stays 0, fu_ready=3'b111; rr_ptr unchanged for next grant.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// -----------------------------------------------------------------------------
// tomasulo_pkg
// Definitions shared by the CDB arbiter, the reservation stations and the
// register bank: producer tag width, result value width, and the reserved
// "no producer" tag.
// -----------------------------------------------------------------------------
package tomasulo_pkg;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 16;

    // A tag of zero means "no producer": such results carry nothing a
    // consumer could be waiting on, so they are never broadcast.
    localparam logic [TAG_W-1:0] NULL_TAG = '0;

endpackage

// File: rtl/cdb_fifo.sv
// -----------------------------------------------------------------------------
// cdb_fifo
// Small per-unit result FIFO sitting between a functional unit and the CDB
// arbiter. Holds {tag, data} entries in arrival order.
//
// Ports:
//   clk1   in   clock, all updates on posedge
//   rst    in   asynchronous active-high reset (empties the FIFO)
//   push   in   write din this cycle (ignored when full)
//   pop    in   drop the head entry this cycle (ignored when empty)
//   clr    in   synchronous clear, wins over push and pop
//   din    in   entry to write
//   dout   out  current head entry (meaningful only when count != 0)
//   count  out  number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module cdb_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 2
) (
    input  logic                       clk1,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full FIFOs never take a same-cycle push, even if they are popped.
    assign do_push = push && (count < CNT_W'(DEPTH)) && !clr;
    assign do_pop  = pop  && (count != '0) && !clr;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by overflow.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read
    // after it has been written, and leaving it out keeps it plain RAM.
    always_ff @(posedge clk1) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/tomasulo_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tomasulo_cdb_arbiter
// Collects completed results from NUM_FU functional units into per-unit
// FIFOs, grants one non-empty FIFO per cycle in round-robin order and
// broadcasts the winner on a registered Common Data Bus.
//
// Ports:
//   clk1      in   clock
//   rst       in   asynchronous active-high reset
//   flush     in   synchronous discard of all buffered results
//   fu_valid  in   [NUM_FU]          unit i presents a result
//   fu_ready  out  [NUM_FU]          FIFO i can accept (registered count only)
//   fu_tag    in   [NUM_FU*TAG_W]    tag of unit i at [i*TAG_W +: TAG_W]
//   fu_data   in   [NUM_FU*DATA_W]   value of unit i, same packing
//   cdb_valid out  broadcast valid this cycle
//   cdb_tag   out  broadcast producer tag (holds when idle)
//   cdb_data  out  broadcast value (holds when idle)
//   drop_cnt  out  saturating count of null-tag results discarded
// -----------------------------------------------------------------------------
module tomasulo_cdb_arbiter #(
    parameter int NUM_FU     = 3,
    parameter int DATA_W     = tomasulo_pkg::DATA_W,
    parameter int TAG_W      = tomasulo_pkg::TAG_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk1,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_FU-1:0]        fu_valid,
    output logic [NUM_FU-1:0]        fu_ready,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
    input  logic [NUM_FU*DATA_W-1:0] fu_data,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [7:0]               drop_cnt
);

    import tomasulo_pkg::*;

    localparam int ENTRY_W = TAG_W + DATA_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [CNT_W-1:0]   fifo_count [NUM_FU];
    logic [ENTRY_W-1:0] fifo_head  [NUM_FU];
    logic [NUM_FU-1:0]  nonempty;
    logic [NUM_FU-1:0]  push;
    logic [NUM_FU-1:0]  pop;
    logic [NUM_FU-1:0]  drop;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_next;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_valid;
    logic [7:0]         drop_next;

    // ------------------------------------------------------------------
    // Per-unit intake
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              accept;

        assign tag  = fu_tag[g*TAG_W +: TAG_W];
        assign data = fu_data[g*DATA_W +: DATA_W];

        assign fu_ready[g] = fifo_count[g] < CNT_W'(FIFO_DEPTH);
        assign nonempty[g] = fifo_count[g] != '0;

        // Null-tag results complete the handshake but are not stored.
        assign accept  = fu_valid[g] && fu_ready[g] && !flush;
        assign push[g] = accept && (tag != TAG_W'(NULL_TAG));
        assign drop[g] = accept && (tag == TAG_W'(NULL_TAG));
        assign pop[g]  = grant_valid && (grant_idx == PTR_W'(g));

        cdb_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk1  (clk1),
            .rst   (rst),
            .push  (push[g]),
            .pop   (pop[g]),
            .clr   (flush),
            .din   ({tag, data}),
            .dout  (fifo_head[g]),
            .count (fifo_count[g])
        );
    end

    // ------------------------------------------------------------------
    // Round-robin grant: first non-empty FIFO at or after rr_ptr.
    // ------------------------------------------------------------------
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first so no
        // path through the block leaves it unassigned (no latches).
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_FU;
            if (!grant_valid && nonempty[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = PTR_W'(idx);
            end
        end
        if (flush) grant_valid = 1'b0;

        rr_next = (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Several units may drop in the same cycle; add them all, saturating.
    always_comb begin
        int sum;
        sum = int'(drop_cnt);
        for (int i = 0; i < NUM_FU; i++) begin
            if (drop[i]) sum = sum + 1;
        end
        drop_next = (sum > 255) ? 8'hFF : 8'(sum);
    end

    // ------------------------------------------------------------------
    // CDB register, round-robin pointer, drop counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            rr_ptr    <= '0;
            drop_cnt  <= '0;
        end else if (flush) begin
            // Pointer and drop count deliberately survive a flush.
            cdb_valid <= 1'b0;
        end else begin
            cdb_valid <= grant_valid;
            drop_cnt  <= drop_next;
            if (grant_valid) begin
                {cdb_tag, cdb_data} <= fifo_head[grant_idx];
                rr_ptr              <= rr_next;
            end
        end
    end

endmodule
